// File: rtl/restador_serial_7_bits.sv
// restador_serial_7_bits
//   Bit-serial unsigned subtractor: diferencia = (A - B) mod 2^WIDTH,
//   processed LSB first, one bit per clock. A start pulse in IDLE captures
//   the operands; WIDTH edges later the result is written and done pulses.
//   Results are held until the next completed operation.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset (aborts any operation)
//   start      : launch request, only looked at while idle
//   A, B       : minuend / subtrahend, captured on the accepted start edge
//   busy       : high while an operation is in progress
//   done       : one-cycle pulse on the edge the result is written
//   diferencia : (A - B) mod 2^WIDTH, held between operations
//   borrow     : 1 when A < B (borrow out of the MSB), held with diferencia
module restador_serial_7_bits #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diferencia,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             a0;
  logic             b0;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // One full-subtractor cell applied to the current LSBs. The new bit enters
  // the result from the MSB side so that after WIDTH shifts bit 0 sits at
  // position 0; res_next already contains the current bit, which lets the
  // completion edge publish the finished word without an extra cycle.
  always_comb begin
    a0       = reg_a[0];
    b0       = reg_b[0];
    d        = a0 ^ b0 ^ br;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_next = {d, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      reg_a      <= '0;
      reg_b      <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diferencia <= '0;
      borrow     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            reg_a <= A;
            reg_b <= B;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // start is deliberately not examined here: no restart, no queueing.
          reg_a <= reg_a >> 1;
          reg_b <= reg_b >> 1;
          res   <= res_next;
          br    <= br_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            diferencia <= res_next;
            borrow     <= br_next;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restador_serial_7_bits.sv
module tb_restador_serial_7_bits;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] A;
  logic [6:0] B;
  logic       busy;
  logic       done;
  logic [6:0] diferencia;
  logic       borrow;

  int errors = 0;
  int checks = 0;

  // Expected results, {borrow, diferencia}, pushed when an operation is accepted.
  logic [7:0] sb[$];

  restador_serial_7_bits #(.WIDTH(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .diferencia (diferencia),
    .borrow     (borrow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) begin
        checks++;
        errors++;
        $display("FAIL busy_done_overlap: actual=busy&done required=exclusive");
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual={%0b,%0h} required=no_done", borrow, diferencia);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          chk("result_diferencia", {25'd0, diferencia}, {25'd0, e[6:0]});
          chk("result_borrow", {31'd0, borrow}, {31'd0, e[7]});
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of edge k+8.
  task automatic op_timed(input logic [6:0] a, input logic [6:0] b,
                          input logic [6:0] exp_d, input logic exp_b);
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    sb.push_back({exp_b, exp_d});
    #1;
    start = 1'b0;
    A = ~a;
    B = ~b;
    chk("busy_at_k", {31'd0, busy}, 32'd1);
    for (int i = 1; i < 7; i++) begin
      @(posedge clk); #1;
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_early", {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
    chk("done_at_k7", {31'd0, done}, 32'd1);
    chk("busy_at_k7", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("done_at_k8", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dif", {25'd0, diferencia}, 32'd0);
    chk("reset_borrow", {31'd0, borrow}, 32'd0);
    @(posedge clk); #1;

    // Directed vectors
    op_timed(7'h41, 7'h20, 7'h21, 1'b0);
    op_timed(7'h20, 7'h41, 7'h5F, 1'b1);
    op_timed(7'h00, 7'h01, 7'h7F, 1'b1);
    op_timed(7'h7F, 7'h7F, 7'h00, 1'b0);

    // Round trip: S = (0x61 + B) mod 128, S - B must give 0x61.
    for (int b = 0; b < 128; b++) begin
      logic [7:0] s;
      s = 8'h61 + 8'(b);
      op_timed(s[6:0], 7'(b), 7'h61, s[7]);
    end

    // Start pulses during RUN are ignored.
    start = 1'b1;
    A = 7'h50;
    B = 7'h13;
    @(posedge clk);
    sb.push_back({1'b0, 7'h3D});
    #1;
    start = 1'b0;
    A = 7'h01;
    B = 7'h02;
    @(posedge clk);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 7'h03;
    B = 7'h04;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("ign_done_k7", {31'd0, done}, 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("ign_busy_k8", {31'd0, busy}, 32'd0);
    chk("ign_done_k8", {31'd0, done}, 32'd0);

    // Reset mid-RUN aborts without a done pulse.
    start = 1'b1;
    A = 7'h10;
    B = 7'h05;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dif", {25'd0, diferencia}, 32'd0);
    chk("abort_borrow", {31'd0, borrow}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", {31'd0, done}, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    op_timed(7'h7A, 7'h0B, 7'h6F, 1'b0);

    // Start held high: accepted every 8 cycles.
    start = 1'b1;
    A = 7'h35;
    B = 7'h30;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      sb.push_back({1'b0, 7'h05});
      #1;
      chk("cont_busy", {31'd0, busy}, 32'd1);
      if (i == 2) start = 1'b0;
      else begin
        repeat (7) @(posedge clk);
        #1;
        chk("cont_done", {31'd0, done}, 32'd1);
      end
    end
    repeat (8) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/restador_serial_7_bits.md
# restador_serial_7_bits

Bit-serial 7-bit subtractor that computes A − B on ASCII codes, LSB first, one bit per clock. It is the inverse of the 7-bit ASCII adder path: given a sum and one addend, it recovers the other addend, or computes the distance between two characters. A start/busy/done handshake launches each operation, and results are registered and held between operations.

## Interface
- WIDTH, 7, operand and result width in bits; the counter is sized to count to WIDTH.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while the FSM is in IDLE.
- A  input  WIDTH  minuend; captured on the accepted start edge.
- B  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when a result is written.
- diferencia  output  WIDTH  (A − B) mod 2^WIDTH; held until the next done.
- borrow  output  1  1 when A < B unsigned; held with diferencia.

## Operation
- Reset values: FSM = IDLE; busy = 0, done = 0, diferencia = 0, borrow = 0. Internal shift registers, borrow flop and bit counter are all cleared.
- States: IDLE and RUN.
- IDLE with start = 1:
  - Latch A into reg_a and B into reg_b.
  - Clear the borrow flop br and set cnt = 0.
  - Set busy = 1 and go to RUN.
- IDLE with start = 0: remain in IDLE.
- RUN, on each edge:
  - a0 = reg_a[0], b0 = reg_b[0].
  - d = a0 ^ b0 ^ br.
  - br ← (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift reg_a and reg_b right by one.
  - Shift d into the result shift register from the MSB side.
  - cnt ← cnt + 1.
- RUN, on the edge where cnt = WIDTH−1 (the last bit):
  - diferencia ← final result register contents, including the current d.
  - borrow ← final br value.
  - done ← 1, busy ← 0, FSM → IDLE.
- done is forced to 0 on every edge except the completion edge.
- start is ignored while in RUN: no restart and no queueing, and the captured operands stay unchanged.
- A and B may change freely after the capture edge without affecting the result.
- Arithmetic is unsigned modulo 2^WIDTH; borrow is the borrow out of the MSB.
- Round-trip property: if S = (X + Y) mod 128, then subtracting Y from S returns X.
- rst asserted at any point, including mid-RUN:
  - Return to IDLE with all outputs at their reset values.
  - The aborted operation produces no done pulse.
- rst has priority over start on the same edge.

## Timing
- start sampled high at edge k (FSM in IDLE):
  - busy = 1 from edge k.
  - Bits 0..WIDTH−1 are processed at edges k+1..k+WIDTH.
  - At edge k+WIDTH (k+7 by default): diferencia and borrow are valid, done = 1 and busy = 0.
  - At edge k+WIDTH+1: done = 0.
- Latency from start to done is WIDTH cycles.
- The earliest next accepted start is edge k+WIDTH+1, i.e. start held high during the done cycle. Back-to-back throughput is therefore one operation per WIDTH+1 cycles.
- done and busy are never high in the same cycle.
- Outputs are register-driven; there is no combinational path from any input to any output.

## Test plan
- 0x41 − 0x20, start pulsed at edge k -> done at k+7 only; diferencia = 0x21, borrow = 0; busy high for exactly 7 cycles.
- 0x20 − 0x41 -> diferencia = 0x5F, borrow = 1. Also 0x00 − 0x01 -> 0x7F with borrow = 1, and 0x7F − 0x7F -> 0x00 with borrow = 0.
- Round-trip: for all B with A = 0x61, feed S = (0x61 + B) mod 128 as minuend and B as subtrahend -> diferencia = 0x61 every time; borrow = 1 exactly when the adder carried.
- start pulsed again at edges k+3 and k+7, with different A and B -> ignored; the result is from the first operands only; a single done at k+7.
- rst asserted at k+4 mid-RUN -> next cycle busy = 0, done = 0, diferencia = 0, borrow = 0; no done follows. A start after reset completes normally.
- start held high continuously with operands 0x35 − 0x30 -> operations accepted at k, k+8, k+16, ...; each produces a done pulse with diferencia = 0x05, borrow = 0.
